imem_loader: RTL and testbench

Boot-time program loader that writes the byte-addressed instruction memory in the fetch stage. It accepts a byte stream over a valid/ready handshake: a 4-byte big-endian length header followed by the payload. It writes each payload byte to consecutive memory addresses starting at 0. While loading, it holds the core in reset-stall. It is the write side of the instruction ROM's byte array, and it uses the same byte order: byte at address n+0 is the word MSB.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_checksum.sv | 36 +++
 rtl/imem_loader.sv | 156 +++++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam int HDR_BYTES      = 4;
  localparam int CHECKSUM_WIDTH = 8;

endpackage

// File: rtl/imem_loader_checksum.sv
// Modulo-256 payload sum and compare, used only when LOADER_CHECKSUM_EN is defined.
module loader_checksum
  import imem_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      add_en,
  input  logic [CHECKSUM_WIDTH-1:0] data,
  output logic                      match
);

  logic [CHECKSUM_WIDTH-1:0] acc_q;
  logic [CHECKSUM_WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Compared against the byte currently on the stream, i.e. the checksum beat.
  assign match = (data == acc_q);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into instruction memory while stalling the core.
// Optional macro LOADER_CHECKSUM_EN adds a trailing modulo-256 checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_BYTES     = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     s_valid,
  input  logic [DATA_WIDTH-1:0]    s_data,
  output logic                     s_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     checksum_ok,
  output loader_state_t            dbg_state
);

  localparam logic [ADDRESS_WIDTH-1:0] ONE       = 1;
  localparam logic [ADDRESS_WIDTH-1:0] HDR_LAST  = ADDRESS_WIDTH'(HDR_BYTES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] MEM_LIMIT = ADDRESS_WIDTH'(MEM_BYTES);
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t PAYLOAD_END = ST_CHECK;
`else
  localparam loader_state_t PAYLOAD_END = ST_DONE;
`endif

  loader_state_t            state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] len_q, len_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [ADDRESS_WIDTH-1:0] hdr_len;
  logic                     xfer;

  // Handshake: a byte moves on any cycle with s_valid && s_ready; s_ready depends
  // only on the registered state, never on s_valid, and s_valid may drop at will.
  assign s_ready = (state_q == ST_HDR) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign xfer    = s_valid && s_ready;
  assign hdr_len = {len_q[ADDRESS_WIDTH-DATA_WIDTH-1:0], s_data};

`ifdef LOADER_CHECKSUM_EN
  logic sum_clear;
  logic sum_add;
  logic sum_match;

  loader_checksum u_checksum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (sum_clear),
    .add_en (sum_add),
    .data   (s_data[CHECKSUM_WIDTH-1:0]),
    .match  (sum_match)
  );

  assign sum_clear = (state_q == ST_IDLE || state_q == ST_DONE) && start;
  assign sum_add   = xfer && (state_q == ST_LOAD);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_HDR;
          cnt_d   = '0;
          len_d   = '0;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          len_d = hdr_len;
          if (cnt_q == HDR_LAST) begin
            cnt_d = '0;
            // Full-width compare, so oversize headers never wrap into range.
            if (hdr_len > MEM_LIMIT) begin
              state_d = ST_ERROR;
            end else if (hdr_len == '0) begin
              state_d = PAYLOAD_END;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q;
          mem_wdata_d = s_data;
          cnt_d       = cnt_q + ONE;
          if (cnt_q == len_q - ONE) begin
            state_d = PAYLOAD_END;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) begin
          state_d = sum_match ? ST_DONE : ST_ERROR;
        end
      end
`endif
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = s_ready;
  assign done        = (state_q == ST_DONE);
  assign error       = (state_q == ST_ERROR);
  // DONE is reachable only through a matching checksum when one is required.
  assign checksum_ok = (state_q == ST_DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes queued by the driver, popped by a monitor.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 8;
  localparam int MEM = 4096;
  localparam int W   = 32 + AW + DW;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, mem_we, busy, done, error, checksum_ok;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  loader_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_xfer_cyc = 0;
  int last_xfer_cyc = 0;
  bit alt_gap = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [DW-1:0] pay[$];
  logic [W-1:0] mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .checksum_ok (checksum_ok),
    .dbg_state   (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h expected=no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_cycle", W'(cyc), W'(mon_e[W-1 -: 32]));
        check("write_addr", W'(mem_addr), W'(mon_e[AW+DW-1 -: AW]));
        check("write_data", W'(mem_wdata), W'(mon_e[DW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycle();
    s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    start = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Returns #1 after the edge on which the byte was accepted.
  task automatic send_byte(input logic [DW-1:0] b, input int gap_pct);
    int n;
    bit ok;
    for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) idle_cycle();
    s_valid = 1'b1;
    s_data = b;
    n = 0;
    ok = 1'b0;
    while (n < 20 && !ok) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      else n++;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=s_ready low 20 cycles expected=byte accepted");
    end
    s_valid = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] len, input int gap_pct);
    for (int i = 0; i < 4; i++) send_byte(len[31-8*i -: 8], gap_pct);
  endtask

  // Reference model: payload byte k lands at address k only when length fits memory;
  // the session fails on oversize length or on a wrong trailing sum.
  task automatic run_session(input logic [31:0] len, input int gap_pct, input logic [7:0] cs_xor);
    logic [7:0] sum;
    logic exp_err;
    sum = 8'h00;
    exp_err = (len > 32'(MEM)) || (CS_EN && cs_xor != 8'h00);
    do_start();
    check("hdr_busy", W'(busy), W'(1'b1));
    send_header(len, gap_pct);
    if (len <= 32'(MEM)) begin
      for (int k = 0; k < int'(len); k++) begin
        if (alt_gap && k > 0) begin
          start = 1'b1;
          idle_cycle();
          start = 1'b0;
        end
        send_byte(pay[k], gap_pct);
        if (k == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        exp_q.push_back({32'(cyc), 32'(k), pay[k]});
        sum = sum + pay[k];
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(sum ^ cs_xor, gap_pct);
`endif
    end
    check("end_done", W'(done), W'(!exp_err));
    check("end_error", W'(error), W'(exp_err));
    check("end_busy", W'(busy), W'(1'b0));
    check("end_checksum_ok", W'(checksum_ok), W'(!exp_err));
    check("end_ready", W'(s_ready), W'(1'b0));
    repeat (2) idle_cycle();
    check("drain", W'(exp_q.size()), W'(0));
    if (exp_err) begin
      // Error is sticky: start and further stream bytes must do nothing.
      do_start();
      s_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      s_valid = 1'b0;
      check("err_sticky", W'(error), W'(1'b1));
      check("err_busy", W'(busy), W'(1'b0));
      check("err_ready", W'(s_ready), W'(1'b0));
      apply_reset();
    end
  endtask

  task automatic fill_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, W'(s_ready), W'(0));
    check({tag, "_mem_we"}, W'(mem_we), W'(0));
    check({tag, "_mem_addr"}, W'(mem_addr), W'(0));
    check({tag, "_mem_wdata"}, W'(mem_wdata), W'(0));
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_done"}, W'(done), W'(0));
    check({tag, "_error"}, W'(error), W'(0));
    check({tag, "_checksum_ok"}, W'(checksum_ok), W'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rlen;
    #1;
    check_reset_outputs("reset");
    check("reset_state", W'(dbg_state), W'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed image, stream held valid: four writes on consecutive cycles.
    pay = '{8'h13, 8'h05, 8'h00, 8'h00};
    run_session(32'd4, 0, 8'h00);
    check("throughput_span", W'(last_xfer_cyc - first_xfer_cyc), W'(3));

    // Oversize headers, including one that would wrap a narrow compare.
    run_session(32'd4097, 0, 8'h00);
    run_session(32'hFFFF_FFFF, 0, 8'h00);

    // Valid toggling 1,0,1,0,1 with start pulsed on the idle cycles.
    fill_pay(3);
    alt_gap = 1'b1;
    run_session(32'd3, 0, 8'h00);
    alt_gap = 1'b0;

    // Empty image.
    pay.delete();
    run_session(32'd0, 0, 8'h00);

    // Asynchronous reset after 2 of 8 payload bytes.
    fill_pay(8);
    do_start();
    send_header(32'd8, 0);
    for (int k = 0; k < 2; k++) begin
      send_byte(pay[k], 0);
      exp_q.push_back({32'(cyc), 32'(k), pay[k]});
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill_pay(1);
    run_session(32'd1, 0, 8'h00);

`ifdef LOADER_CHECKSUM_EN
    pay = '{8'hFF, 8'h02};
    run_session(32'd2, 0, 8'h00);
    pay = '{8'hFF, 8'h02};
    run_session(32'd2, 0, 8'h03);
`endif

    // Exactly full memory: last write lands at 0xFFF.
    fill_pay(MEM);
    run_session(32'(MEM), 0, 8'h00);

    // Randomized sessions.
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(0, 7) == 0) rlen = 32'(MEM) + 32'($urandom_range(1, 100000));
      else rlen = 32'($urandom_range(0, 24));
      if (rlen <= 32'(MEM)) fill_pay(int'(rlen));
      run_session(rlen, int'($urandom_range(0, 50)),
                  ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
